seq_101_tx: RTL

//   Serial pattern transmitter: the sending end of the "101" sequence-detect link.

---
 rtl/seq_101_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seq_101_tx.sv
// ============================================================================
// Module  : seq_101_tx
// Brief   : Serial "101"-link pattern transmitter; shifts a loaded word out
//           MSB-first with optional contiguous repeats. Optional macro
//           SYNC_PREAMBLE_EN prefixes each load with a 1,0,1 preamble.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_101_tx #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load_valid,
   input  logic [WORD_W-1:0] i_load_data,
   input  logic [CNT_W-1:0]  i_load_rep,
   output logic              o_load_ready,
   output logic              o_out,
   output logic              o_out_valid,
   output logic              o_busy,
   output logic              o_done
);

   localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(WORD_W - 1);

`ifdef SYNC_PREAMBLE_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRE   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;
`endif

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WORD_W-1:0]   r_shreg;
   logic [WORD_W-1:0]   r_hold;
   logic [CNT_W-1:0]    r_rep_cnt;
   logic [BIT_W-1:0]    r_bit_cnt;
   logic                r_out;
   logic                r_out_valid;
   logic                r_done;
`ifdef SYNC_PREAMBLE_EN
   logic [1:0]          r_pre_cnt;
`endif

   logic w_load_ready;
   logic w_accept;
   logic w_last_bit;

   assign w_load_ready = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_accept     = i_load_valid & w_load_ready;
   assign w_last_bit   = (r_bit_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
`ifdef SYNC_PREAMBLE_EN
               w_state_nxt = S_PRE;
`else
               w_state_nxt = S_SHIFT;
`endif
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
`ifdef SYNC_PREAMBLE_EN
         S_PRE: begin
            if (r_pre_cnt == 2'd2) w_state_nxt = S_SHIFT;
         end
`endif
         S_SHIFT: begin
            if (w_last_bit && (r_rep_cnt == '0)) w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Serial outputs lag the state by one cycle, which yields the one-cycle
   // accept-to-first-bit latency and places the done pulse after the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg     <= '0;
         r_hold      <= '0;
         r_rep_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_out       <= 1'b0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
`ifdef SYNC_PREAMBLE_EN
         r_pre_cnt   <= '0;
`endif
      end else begin
         r_out       <= 1'b0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
`ifdef SYNC_PREAMBLE_EN
            S_PRE: begin
               r_out       <= (r_pre_cnt != 2'd1);
               r_out_valid <= 1'b1;
               if (r_pre_cnt != 2'd2) r_pre_cnt <= r_pre_cnt + 2'd1;
            end
`endif
            S_SHIFT: begin
               r_out       <= r_shreg[WORD_W-1];
               r_out_valid <= 1'b1;
               if (!w_last_bit) begin
                  r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt - 1'b1;
               end else if (r_rep_cnt != '0) begin
                  r_shreg   <= r_hold;
                  r_rep_cnt <= r_rep_cnt - 1'b1;
                  r_bit_cnt <= c_BIT_LAST;
               end else begin
                  r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
               end
            end
            S_DONE: r_done <= 1'b1;
            default: ;
         endcase
         if (w_accept) begin
            r_shreg   <= i_load_data;
            r_hold    <= i_load_data;
            r_rep_cnt <= i_load_rep;
            r_bit_cnt <= c_BIT_LAST;
`ifdef SYNC_PREAMBLE_EN
            r_pre_cnt <= '0;
`endif
         end
      end
   end

   assign o_load_ready = w_load_ready;
   assign o_out        = r_out;
   assign o_out_valid  = r_out_valid;
   assign o_done       = r_done;
`ifdef SYNC_PREAMBLE_EN
   assign o_busy       = (r_state == S_PRE) || (r_state == S_SHIFT);
`else
   assign o_busy       = (r_state == S_SHIFT);
`endif

endmodule

`default_nettype wire
